// File: rtl/execute_unit_pkg.sv
// Encodings shared by the execute stage: MIPS opcodes/functs, datapath
// control values and the branch modes carried into the resolve cycle.
package execute_unit_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_ADDIU  = 6'd9;
  localparam logic [5:0] OP_SLTI   = 6'd10;
  localparam logic [5:0] OP_SLTIU  = 6'd11;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_LB     = 6'd32;
  localparam logic [5:0] OP_LH     = 6'd33;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_LBU    = 6'd36;
  localparam logic [5:0] OP_LHU    = 6'd37;
  localparam logic [5:0] OP_SB     = 6'd40;
  localparam logic [5:0] OP_SH     = 6'd41;
  localparam logic [5:0] OP_SW     = 6'd43;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_SLLV = 6'd4;
  localparam logic [5:0] F_SRLV = 6'd6;
  localparam logic [5:0] F_SRAV = 6'd7;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_JALR = 6'd9;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SLTU = 6'd43;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {WA_RD, WA_RT, WA_RA, WA_R0} writeAddrMode_t;
  typedef enum logic [1:0] {WS_NONE, WS_NEXT_PC_ADDRESS, WS_DATA_OUTPUT, WS_RESULT} writeSource_t;
  typedef enum logic [2:0] {MEM_NONE, MEM_BYTE, MEM_HALF, MEM_WORD} memMode_t;
  typedef enum logic [3:0] {
    BR_NONE, BR_JUMP, BR_JUMP_REGISTER, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ
  } branchMode_t;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU with result flags. Shifts act on operandB; the shift
// amount is chosen by the decoder (shamt field, rs[4:0] or 16 for LUI).
module execute_alu
  import execute_unit_pkg::*;
(
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [5:0]  aluFunct,
  input  logic [4:0]  aluShamt,
  output logic [31:0] result,
  output logic        zero,
  output logic        positive,
  output logic        negative
);

  // Operation select; ADD/SUB never trap, so signed and unsigned forms match.
  always_comb begin
    result = '0;
    case (aluFunct)
      F_SLL:          result = operandB << aluShamt;
      F_SRL:          result = operandB >> aluShamt;
      F_SRA:          result = $signed(operandB) >>> aluShamt;
      F_ADD, F_ADDU:  result = operandA + operandB;
      F_SUB, F_SUBU:  result = operandA - operandB;
      F_AND:          result = operandA & operandB;
      F_OR:           result = operandA | operandB;
      F_XOR:          result = operandA ^ operandB;
      F_NOR:          result = ~(operandA | operandB);
      F_SLT:          result = {31'b0, $signed(operandA) < $signed(operandB)};
      F_SLTU:         result = {31'b0, operandA < operandB};
      default:        result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[31];
  assign positive = !zero && !result[31];

endmodule

// File: rtl/execute_unit.sv
// Decode/execute/branch-resolve stage. Decoding and ALU are combinational;
// branch decisions are resolved from a one-cycle delay register.
module execute_unit
  import execute_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] rsValue,
  input  logic [31:0] rtValue,
  input  logic [31:0] pcAddress,
  output logic        registerRead,
  output logic        registerWrite,
  output logic [1:0]  registerWriteAddressMode,
  output logic [1:0]  registerWriteSource,
  output logic [2:0]  readMode,
  output logic [2:0]  writeMode,
  output logic        unsignedLoad,
  output logic [31:0] aluResult,
  output logic        outputZero,
  output logic        outputPositive,
  output logic        outputNegative,
  output logic        shouldUseNewPC,
  output logic [31:0] branchTo
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rtField;
  logic [5:0]  aluFunct;
  logic [4:0]  aluShamt;
  logic        useImmediate, signExtend, zeroOperandB;
  branchMode_t branchMode;
  writeAddrMode_t waMode;
  writeSource_t   wSource;
  memMode_t       rMode, wMode;
  logic [31:0] extImmediate, operandB;

  assign opcode  = instruction[31:26];
  assign funct   = instruction[5:0];
  assign rtField = instruction[20:16];

  // Instruction decode into datapath control; anything unrecognised is a NOP.
  always_comb begin
    registerRead  = 1'b0;
    registerWrite = 1'b0;
    waMode        = WA_R0;
    wSource       = WS_NONE;
    rMode         = MEM_NONE;
    wMode         = MEM_NONE;
    unsignedLoad  = 1'b0;
    aluFunct      = F_ADDU;
    aluShamt      = instruction[10:6];
    useImmediate  = 1'b0;
    signExtend    = 1'b0;
    zeroOperandB  = 1'b0;
    branchMode    = BR_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            registerRead = 1'b1; registerWrite = 1'b1; waMode = WA_RD; wSource = WS_RESULT;
            aluFunct = funct;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            registerRead = 1'b1; registerWrite = 1'b1; waMode = WA_RD; wSource = WS_RESULT;
            // Variable shifts reuse the fixed-shift ALU ops with rs as the amount.
            aluFunct = {funct[5:3], 1'b0, funct[1:0]};
            aluShamt = rsValue[4:0];
          end
          F_JR, F_JALR: begin
            registerRead = 1'b1; zeroOperandB = 1'b1; branchMode = BR_JUMP_REGISTER;
            if (funct == F_JALR) begin
              registerWrite = 1'b1; waMode = WA_RD; wSource = WS_NEXT_PC_ADDRESS;
            end
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rtField == RT_BLTZ || rtField == RT_BGEZ) begin
          registerRead = 1'b1; zeroOperandB = 1'b1;
          branchMode = (rtField == RT_BLTZ) ? BR_BLTZ : BR_BGEZ;
        end
      end
      OP_J, OP_JAL: begin
        branchMode = BR_JUMP;
        if (opcode == OP_JAL) begin
          registerWrite = 1'b1; waMode = WA_RA; wSource = WS_NEXT_PC_ADDRESS;
        end
      end
      OP_BEQ, OP_BNE: begin
        registerRead = 1'b1; aluFunct = F_SUBU;
        branchMode = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_BLEZ, OP_BGTZ: begin
        registerRead = 1'b1; zeroOperandB = 1'b1;
        branchMode = (opcode == OP_BLEZ) ? BR_BLEZ : BR_BGTZ;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        registerRead = 1'b1; registerWrite = 1'b1; waMode = WA_RT; wSource = WS_RESULT;
        useImmediate = 1'b1;
        signExtend = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                     (opcode == OP_SLTI) || (opcode == OP_SLTIU);
        case (opcode)
          OP_SLTI:  aluFunct = F_SLT;
          OP_SLTIU: aluFunct = F_SLTU;
          OP_ANDI:  aluFunct = F_AND;
          OP_ORI:   aluFunct = F_OR;
          OP_XORI:  aluFunct = F_XOR;
          default:  aluFunct = F_ADDU;
        endcase
      end
      OP_LUI: begin
        registerWrite = 1'b1; waMode = WA_RT; wSource = WS_RESULT;
        useImmediate = 1'b1; aluFunct = F_SLL; aluShamt = 5'd16;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        registerRead = 1'b1; registerWrite = 1'b1; waMode = WA_RT; wSource = WS_DATA_OUTPUT;
        useImmediate = 1'b1; signExtend = 1'b1;
        unsignedLoad = (opcode == OP_LBU) || (opcode == OP_LHU);
        case (opcode)
          OP_LB, OP_LBU: rMode = MEM_BYTE;
          OP_LH, OP_LHU: rMode = MEM_HALF;
          default:       rMode = MEM_WORD;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        registerRead = 1'b1; useImmediate = 1'b1; signExtend = 1'b1;
        case (opcode)
          OP_SB:   wMode = MEM_BYTE;
          OP_SH:   wMode = MEM_HALF;
          default: wMode = MEM_WORD;
        endcase
      end
      default: ;
    endcase
  end

  assign registerWriteAddressMode = waMode;
  assign registerWriteSource      = wSource;
  assign readMode                 = rMode;
  assign writeMode                = wMode;

  assign extImmediate = signExtend ? {{16{instruction[15]}}, instruction[15:0]}
                                   : {16'h0000, instruction[15:0]};
  assign operandB = zeroOperandB ? 32'h0 : (useImmediate ? extImmediate : rtValue);

  execute_alu alu (
    .operandA(rsValue),
    .operandB(operandB),
    .aluFunct(aluFunct),
    .aluShamt(aluShamt),
    .result  (aluResult),
    .zero    (outputZero),
    .positive(outputPositive),
    .negative(outputNegative)
  );

  logic [25:0] dJumpIndex;
  logic [31:0] dAlu, dPc;
  logic [15:0] dOffset;
  logic        dZero, dPositive, dNegative;
  branchMode_t dMode;
  logic [31:0] pcPlus4, branchTarget;
  logic        taken;

  // Delay register: holds what the resolver needs for the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dJumpIndex <= '0;
      dAlu       <= '0;
      dPc        <= '0;
      dOffset    <= '0;
      dZero      <= 1'b0;
      dPositive  <= 1'b0;
      dNegative  <= 1'b0;
      dMode      <= BR_NONE;
    end else begin
      dJumpIndex <= instruction[25:0];
      dAlu       <= aluResult;
      dPc        <= pcAddress;
      dOffset    <= instruction[15:0];
      dZero      <= outputZero;
      dPositive  <= outputPositive;
      dNegative  <= outputNegative;
      dMode      <= branchMode;
    end
  end

  assign pcPlus4      = dPc + 32'd4;
  assign branchTarget = pcPlus4 + {{14{dOffset[15]}}, dOffset, 2'b00};

  // Branch resolve from the latched flags; not-taken leaves the PC alone.
  always_comb begin
    taken    = 1'b0;
    branchTo = '0;
    case (dMode)
      BR_JUMP:          branchTo = {pcPlus4[31:28], dJumpIndex, 2'b00};
      BR_JUMP_REGISTER: branchTo = dAlu;
      BR_BEQ:           taken = dZero;
      BR_BNE:           taken = !dZero;
      BR_BLEZ:          taken = dZero || dNegative;
      BR_BGTZ:          taken = dPositive;
      BR_BLTZ:          taken = dNegative;
      BR_BGEZ:          taken = dZero || dPositive;
      default:          ;
    endcase
    if (taken) branchTo = branchTarget;
    shouldUseNewPC = taken || (dMode == BR_JUMP) || (dMode == BR_JUMP_REGISTER);
  end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed cases followed by random instructions
// compared against an instruction-level reference model.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0, rsValue = '0, rtValue = '0, pcAddress = '0;
  logic        registerRead, registerWrite, unsignedLoad;
  logic [1:0]  registerWriteAddressMode, registerWriteSource;
  logic [2:0]  readMode, writeMode;
  logic [31:0] aluResult, branchTo;
  logic        outputZero, outputPositive, outputNegative, shouldUseNewPC;

  int total = 0;
  int bad   = 0;

  execute_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rsValue(rsValue),
    .rtValue(rtValue), .pcAddress(pcAddress), .registerRead(registerRead),
    .registerWrite(registerWrite), .registerWriteAddressMode(registerWriteAddressMode),
    .registerWriteSource(registerWriteSource), .readMode(readMode), .writeMode(writeMode),
    .unsignedLoad(unsignedLoad), .aluResult(aluResult), .outputZero(outputZero),
    .outputPositive(outputPositive), .outputNegative(outputNegative),
    .shouldUseNewPC(shouldUseNewPC), .branchTo(branchTo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rr, rw;
    logic [1:0]  wa, ws;
    logic [2:0]  rm, wm;
    logic        ul, aluValid;
    logic [31:0] alu;
    logic        take;
    logic [31:0] target;
  } exp_t;

  exp_t cur;

  // Instruction-level behaviour written straight from the MIPS definitions.
  function automatic exp_t refModel(input logic [31:0] ins, rs, rt, pc);
    exp_t e;
    int   opc, fn, rtf;
    logic [4:0]  sh;
    logic [31:0] simm, zimm, pc4, bt;
    logic rAlu;
    e = '0; rAlu = 1'b0;
    opc = int'(ins[31:26]); fn = int'(ins[5:0]); rtf = int'(ins[20:16]); sh = ins[10:6];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    pc4 = pc + 32'd4;
    bt = pc4 + (simm << 2);
    case (opc)
      0: begin
        rAlu = 1'b1;
        case (fn)
          0: e.alu = rt << sh;
          2: e.alu = rt >> sh;
          3: e.alu = $signed(rt) >>> sh;
          4: e.alu = rt << rs[4:0];
          6: e.alu = rt >> rs[4:0];
          7: e.alu = $signed(rt) >>> rs[4:0];
          32, 33: e.alu = rs + rt;
          34, 35: e.alu = rs - rt;
          36: e.alu = rs & rt;
          37: e.alu = rs | rt;
          38: e.alu = rs ^ rt;
          39: e.alu = ~(rs | rt);
          42: e.alu = {31'b0, $signed(rs) < $signed(rt)};
          43: e.alu = {31'b0, rs < rt};
          8, 9: begin
            rAlu = 1'b0; e.rr = 1'b1; e.aluValid = 1'b1; e.alu = rs;
            e.take = 1'b1; e.target = rs;
            if (fn == 9) begin e.rw = 1'b1; e.wa = 2'd0; e.ws = 2'd1; end
          end
          default: rAlu = 1'b0;
        endcase
        if (rAlu) begin e.rr = 1'b1; e.rw = 1'b1; e.wa = 2'd0; e.ws = 2'd3; e.aluValid = 1'b1; end
      end
      1: if (rtf == 0 || rtf == 1) begin
        e.rr = 1'b1; e.aluValid = 1'b1; e.alu = rs;
        e.take = (rtf == 0) ? ($signed(rs) < 0) : ($signed(rs) >= 0);
      end
      2, 3: begin
        e.take = 1'b1; e.target = {pc4[31:28], ins[25:0], 2'b00};
        if (opc == 3) begin e.rw = 1'b1; e.wa = 2'd2; e.ws = 2'd1; end
      end
      4, 5: begin
        e.rr = 1'b1; e.aluValid = 1'b1; e.alu = rs - rt;
        e.take = (opc == 4) ? (rs == rt) : (rs != rt);
      end
      6, 7: begin
        e.rr = 1'b1; e.aluValid = 1'b1; e.alu = rs;
        e.take = (opc == 6) ? ($signed(rs) <= 0) : ($signed(rs) > 0);
      end
      8, 9, 10, 11, 12, 13, 14, 15: begin
        e.rr = (opc != 15); e.rw = 1'b1; e.wa = 2'd1; e.ws = 2'd3; e.aluValid = 1'b1;
        case (opc)
          8, 9: e.alu = rs + simm;
          10:   e.alu = {31'b0, $signed(rs) < $signed(simm)};
          11:   e.alu = {31'b0, rs < simm};
          12:   e.alu = rs & zimm;
          13:   e.alu = rs | zimm;
          14:   e.alu = rs ^ zimm;
          default: e.alu = zimm * 32'd65536;
        endcase
      end
      32, 33, 35, 36, 37: begin
        e.rr = 1'b1; e.rw = 1'b1; e.wa = 2'd1; e.ws = 2'd2; e.aluValid = 1'b1;
        e.alu = rs + simm; e.ul = (opc == 36 || opc == 37);
        e.rm = (opc == 32 || opc == 36) ? 3'd1 : (opc == 35) ? 3'd3 : 3'd2;
      end
      40, 41, 43: begin
        e.rr = 1'b1; e.aluValid = 1'b1; e.alu = rs + simm;
        e.wm = (opc == 40) ? 3'd1 : (opc == 41) ? 3'd2 : 3'd3;
      end
      default: ;
    endcase
    if (e.take && (opc >= 1) && (opc != 2) && (opc != 3)) e.target = bt;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, rs, rt, pc);
    instruction = ins; rsValue = rs; rtValue = rt; pcAddress = pc;
    #1;
    cur = refModel(ins, rs, rt, pc);
    check("registerRead", 32'(registerRead), 32'(cur.rr));
    check("registerWrite", 32'(registerWrite), 32'(cur.rw));
    check("readMode", 32'(readMode), 32'(cur.rm));
    check("writeMode", 32'(writeMode), 32'(cur.wm));
    check("unsignedLoad", 32'(unsignedLoad), 32'(cur.ul));
    if (cur.rw) begin
      check("writeAddrMode", 32'(registerWriteAddressMode), 32'(cur.wa));
      check("writeSource", 32'(registerWriteSource), 32'(cur.ws));
    end
    if (cur.aluValid) begin
      check("aluResult", aluResult, cur.alu);
      check("outputZero", 32'(outputZero), 32'(cur.alu == 0));
      check("outputNegative", 32'(outputNegative), 32'(cur.alu[31]));
      check("outputPositive", 32'(outputPositive), 32'(cur.alu != 0 && !cur.alu[31]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("shouldUseNewPC", 32'(shouldUseNewPC), 32'(cur.take));
    check("branchTo", branchTo, cur.take ? cur.target : 32'h0);
  endtask

  int ops[29] = '{0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                  32, 33, 35, 36, 37, 40, 41, 43, 63, 19};
  int fns[22] = '{0, 2, 3, 4, 6, 7, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 1, 5, 10, 63};

  initial begin
    logic [31:0] ins, rs, rt, pc;
    // Reset holds the delay register clear even across a jump.
    drive({6'd2, 26'h0000040}, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("rst useNewPC", 32'(shouldUseNewPC), 32'd0);
    check("rst branchTo", branchTo, 32'h0);
    rst = 1'b0;

    drive({6'd8, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd0, 32'h40);
    check("addi result", aluResult, 32'd4);
    check("addi mode", 32'(registerWriteAddressMode), 32'd1);
    check("addi source", 32'(registerWriteSource), 32'd3);
    check("addi positive", 32'(outputPositive), 32'd1);
    tick();

    drive({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd34}, 32'd3, 32'd7, 32'h44);
    check("sub result", aluResult, 32'hFFFFFFFC);
    check("sub negative", 32'(outputNegative), 32'd1);
    tick();
    drive({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd42}, 32'd3, 32'd7, 32'h48);
    check("slt result", aluResult, 32'd1);
    tick();
    drive({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd43}, 32'hFFFFFFFF, 32'd1, 32'h4C);
    check("sltu result", aluResult, 32'd0);
    tick();
    drive({6'd15, 5'd0, 5'd1, 16'h1234}, 32'hDEADBEEF, 32'h0, 32'h50);
    check("lui result", aluResult, 32'h12340000);
    tick();
    drive({6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'd3}, 32'h0, 32'h80000000, 32'h54);
    check("sra result", aluResult, 32'hF8000000);
    tick();

    drive({6'd4, 5'd1, 5'd2, 16'd3}, 32'd9, 32'd9, 32'h100);
    tick();
    check("beq taken", 32'(shouldUseNewPC), 32'd1);
    check("beq target", branchTo, 32'h110);
    drive({6'd4, 5'd1, 5'd2, 16'd3}, 32'd9, 32'd8, 32'h100);
    tick();
    check("beq not taken", 32'(shouldUseNewPC), 32'd0);

    drive({6'd3, 26'h0000040}, 32'h0, 32'h0, 32'h0);
    check("jal mode", 32'(registerWriteAddressMode), 32'd2);
    check("jal source", 32'(registerWriteSource), 32'd1);
    tick();
    check("jal target", branchTo, 32'h100);
    drive({6'd0, 5'd4, 15'd0, 6'd8}, 32'h2000, 32'h0, 32'h200);
    tick();
    check("jr target", branchTo, 32'h2000);

    // Async reset right after a taken branch edge.
    drive({6'd4, 5'd1, 5'd2, 16'd3}, 32'd1, 32'd1, 32'h100);
    tick();
    rst = 1'b1;
    #1;
    check("async rst useNewPC", 32'(shouldUseNewPC), 32'd0);
    check("async rst branchTo", branchTo, 32'h0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[31:26] = 6'(ops[$urandom_range(0, 28)]);
      if (ins[31:26] == 6'd0) ins[5:0] = 6'(fns[$urandom_range(0, 21)]);
      if (ins[31:26] == 6'd1) ins[20:16] = 5'($urandom_range(0, 2));
      rt = $urandom;
      case ($urandom_range(0, 4))
        0: rs = 32'h0;
        1: rs = rt;
        2: rs = 32'h80000000 | $urandom;
        default: rs = $urandom;
      endcase
      pc = $urandom & 32'hFFFFFFFC;
      drive(ins, rs, rt, pc);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
